// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx - serial transmitter half of the UART pair.
//
// Frames one byte as start(0), 8 data bits LSB-first, optional even parity,
// stop(1). Every serial bit is held for CLKS_PER_BIT clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> PARITY state between DATA and STOP, frame = 11 bits
//   undefined -> no parity logic, frame = 10 bits
//
// Ports
//   clk         in   1  system clock, rising edge
//   n_rst       in   1  asynchronous active-low reset
//   tx_data     in   8  byte to send, sampled only when tx_start is accepted
//   tx_start    in   1  send request, accepted while the FSM is idle
//   tx_busy     out  1  high while a frame is in progress (START..STOP)
//   tx_done     out  1  one-cycle pulse in the first idle cycle after a frame
//   serial_out  out  1  TX line, idle high
//   o_dbg_state out  3  current FSM state encoding, for observation only
//
// Handshake: tx_start is sampled on a rising edge; it is accepted only when
// the FSM is idle (which includes the tx_done cycle, so frames can run
// back-to-back). A request that is not accepted is dropped, never queued.
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_BITS     = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       serial_out,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    localparam logic [CNT_BITS-1:0] BAUD_LAST = CNT_BITS'(CLKS_PER_BIT - 1);

    state_t              r_state;
    logic [CNT_BITS-1:0] r_baud;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shreg;
    logic                r_serial;
    logic                r_busy;
    logic                r_done;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
    logic                w_next_parity;
`endif

    state_t              w_next_state;
    logic [CNT_BITS-1:0] w_next_baud;
    logic [2:0]          w_next_bit_cnt;
    logic [7:0]          w_next_shreg;
    logic                w_next_serial;
    logic                w_next_busy;
    logic                w_next_done;
    logic                w_bit_tick;

    // Last cycle of the current serial bit.
    assign w_bit_tick = (r_baud == BAUD_LAST);

    always_comb begin
        w_next_state   = r_state;
        w_next_baud    = r_baud;
        w_next_bit_cnt = r_bit_cnt;
        w_next_shreg   = r_shreg;
        w_next_serial  = r_serial;
        w_next_busy    = r_busy;
        w_next_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_next_parity  = r_parity;
`endif

        // Baud counter runs in every active state and wraps on the bit tick.
        if (r_state != S_IDLE) begin
            w_next_baud = w_bit_tick ? '0 : r_baud + CNT_BITS'(1);
        end

        // The serial line value is computed for the *next* state so that
        // serial_out comes straight from a flop and cannot glitch.
        unique case (r_state)
            S_IDLE: begin
                w_next_serial = 1'b1;
                w_next_busy   = 1'b0;
                if (tx_start) begin
                    w_next_state   = S_START;
                    w_next_baud    = '0;
                    w_next_bit_cnt = '0;
                    w_next_shreg   = tx_data;
                    w_next_serial  = 1'b0;
                    w_next_busy    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    w_next_parity  = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (w_bit_tick) begin
                    w_next_state  = S_DATA;
                    w_next_serial = r_shreg[0];
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_next_state  = S_PARITY;
                        w_next_serial = r_parity;
`else
                        w_next_state  = S_STOP;
                        w_next_serial = 1'b1;
`endif
                    end else begin
                        w_next_bit_cnt = r_bit_cnt + 3'd1;
                        w_next_shreg   = {1'b0, r_shreg[7:1]};
                        // Bit about to be shifted into position 0.
                        w_next_serial  = r_shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_next_state  = S_STOP;
                    w_next_serial = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_tick) begin
                    w_next_state  = S_IDLE;
                    w_next_serial = 1'b1;
                    w_next_busy   = 1'b0;
                    w_next_done   = 1'b1;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_serial = 1'b1;
                w_next_busy   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_baud    <= w_next_baud;
            r_bit_cnt <= w_next_bit_cnt;
            r_shreg   <= w_next_shreg;
            r_serial  <= w_next_serial;
            r_busy    <= w_next_busy;
            r_done    <= w_next_done;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_next_parity;
`endif
        end
    end

    assign serial_out  = r_serial;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;
  localparam int LIMIT = FRAME_CYCLES + 50;

  // clock / reset
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       serial_out;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_BITS(10)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .serial_out (serial_out),
    .o_dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // per-cycle capture of one frame, index 0 = first start-bit cycle
  logic cap_line[$];
  logic cap_busy[$];

  // expected line level per bit slot: start, data LSB-first, [parity], stop
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // driver: request a frame; returns at the negedge of the first start-bit cycle.
  // tx_data is scrambled right after acceptance; the frame must not follow it.
  task automatic start_frame(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  // monitor: records the line until tx_done; optionally pokes tx_start mid-frame
  task automatic capture_frame(input int poke_at, input logic [7:0] poke_data,
                               output int done_at);
    cap_line.delete();
    cap_busy.delete();
    done_at = -1;
    for (int cyc = 0; cyc <= LIMIT; cyc++) begin
      cap_line.push_back(serial_out);
      cap_busy.push_back(tx_busy);
      if (tx_done === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (cyc == poke_at) begin
        tx_start = 1'b1;
        tx_data  = poke_data;
      end else if (cyc == poke_at + 1) begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    total++;
    if (done_at < 0) begin
      bad++;
      $display("FAIL frame_timeout: no tx_done within %0d cycles", LIMIT);
    end
  endtask

  task automatic test_reset;
    int errs;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_serial: got %b want 1", serial_out); end
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    total++;
    if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL idle_20: bad cycles got %0d want 0", errs); end
  endtask

  task automatic test_frame_a5;
    int done_at;
    int errs;
    logic [10:0] exp;
    exp = frame_bits(8'hA5);
    start_frame(8'hA5);
    capture_frame(-1, 8'h00, done_at);
    total++;
    if (done_at != FRAME_CYCLES) begin bad++; $display("FAIL a5_length: got %0d want %0d", done_at, FRAME_CYCLES); end
    errs = 0;
    for (int c = 0; c < done_at; c++) begin
      if (cap_line[c] !== exp[c / CPB]) errs++;
      if (cap_busy[c] !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL a5_bits: bad cycles got %0d want 0", errs); end
    if (done_at >= 0) begin
      total++;
      if (cap_busy[done_at] !== 1'b0 || cap_line[done_at] !== 1'b1) begin
        bad++;
        $display("FAIL a5_done_cycle: busy=%b line=%b want busy=0 line=1", cap_busy[done_at], cap_line[done_at]);
      end
    end
    @(negedge clk);
    total++;
    if (tx_done !== 1'b0) begin bad++; $display("FAIL a5_done_width: got %b want 0", tx_done); end
  endtask

  task automatic test_back_to_back;
    int done_at;
    int errs;
    logic [10:0] exp;
    start_frame(8'h3C);
    capture_frame(-1, 8'h00, done_at);
    exp = frame_bits(8'h3C);
    errs = 0;
    for (int c = 0; c < done_at; c++) if (cap_line[c] !== exp[c / CPB]) errs++;
    total++;
    if (errs != 0 || done_at != FRAME_CYCLES) begin
      bad++;
      $display("FAIL b2b_first: bad cycles %0d length %0d want 0 and %0d", errs, done_at, FRAME_CYCLES);
    end
    // request in the tx_done cycle
    start_frame(8'hC3);
    total++;
    if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: line=%b busy=%b want line=0 busy=1", serial_out, tx_busy);
    end
    capture_frame(-1, 8'h00, done_at);
    exp = frame_bits(8'hC3);
    errs = 0;
    for (int c = 0; c < done_at; c++) if (cap_line[c] !== exp[c / CPB]) errs++;
    total++;
    if (errs != 0 || done_at != FRAME_CYCLES) begin
      bad++;
      $display("FAIL b2b_second: bad cycles %0d length %0d want 0 and %0d", errs, done_at, FRAME_CYCLES);
    end
  endtask

  task automatic test_ignore_busy;
    int done_at;
    int errs;
    logic [10:0] exp;
    @(negedge clk);
    start_frame(8'h00);
    capture_frame(1000, 8'hFF, done_at);
    exp = frame_bits(8'h00);
    errs = 0;
    for (int c = 0; c < done_at; c++) if (cap_line[c] !== exp[c / CPB]) errs++;
    total++;
    if (errs != 0 || done_at != FRAME_CYCLES) begin
      bad++;
      $display("FAIL ignore_frame: bad cycles %0d length %0d want 0 and %0d", errs, done_at, FRAME_CYCLES);
    end
    errs = 0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL ignore_no_queue: bad cycles got %0d want 0", errs); end
  endtask

  task automatic test_reset_mid_frame;
    int done_at;
    int errs;
    logic [10:0] exp;
    start_frame(8'h00);
    repeat (3 * CPB + 5) @(negedge clk);
    total++;
    if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_before: line=%b busy=%b want line=0 busy=1", serial_out, tx_busy);
    end
    n_rst = 1'b0;
    #1;
    total++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: line=%b busy=%b done=%b want 1 0 0", serial_out, tx_busy, tx_done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    start_frame(8'h81);
    capture_frame(-1, 8'h00, done_at);
    exp = frame_bits(8'h81);
    errs = 0;
    for (int c = 0; c < done_at; c++) if (cap_line[c] !== exp[c / CPB]) errs++;
    total++;
    if (errs != 0 || done_at != FRAME_CYCLES) begin
      bad++;
      $display("FAIL midrst_after: bad cycles %0d length %0d want 0 and %0d", errs, done_at, FRAME_CYCLES);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int done_at;
    @(negedge clk);
    start_frame(8'h07);
    capture_frame(-1, 8'h00, done_at);
    total++;
    if (done_at != 4774) begin bad++; $display("FAIL par07_length: got %0d want 4774", done_at); end
    if (done_at > 9 * CPB) begin
      total++;
      if (cap_line[9 * CPB + CPB / 2] !== 1'b1) begin
        bad++;
        $display("FAIL par07_bit: got %b want 1", cap_line[9 * CPB + CPB / 2]);
      end
    end
    @(negedge clk);
    start_frame(8'hA5);
    capture_frame(-1, 8'h00, done_at);
    total++;
    if (done_at != 4774) begin bad++; $display("FAIL parA5_length: got %0d want 4774", done_at); end
    if (done_at > 9 * CPB) begin
      total++;
      if (cap_line[9 * CPB + CPB / 2] !== 1'b0) begin
        bad++;
        $display("FAIL parA5_bit: got %b want 0", cap_line[9 * CPB + CPB / 2]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    @(negedge clk);
    test_frame_a5();
    @(negedge clk);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
